// File: rtl/clock_time_ctrl.sv
// MM:SS timekeeping sequencer: 1 Hz prescaler, RUN/SET_MIN/SET_SEC mode machine,
// digit-counter enable steering and set-mode blink generation.
module clock_time_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tc_sec_ones,
    input  logic       tc_sec_tens,
    input  logic       tc_min_ones,
    output logic       en_sec_ones,
    output logic       en_sec_tens,
    output logic       en_min_ones,
    output logic       en_min_tens,
    output logic [1:0] mode,
    output logic       tick,
    output logic       blink
);

    localparam int unsigned PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10,
        ILLEGAL = 2'b11
    } mode_t;

    mode_t              state, state_d;
    logic [PRE_W-1:0]   pre, pre_d;
    logic [BLINK_W-1:0] bcnt, bcnt_d;
    logic               tick_d, inc_r, inc_d, blink_d;
    logic               mode_chg;
    logic               in_set;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pre   <= '0;
            tick  <= 1'b0;
            inc_r <= 1'b0;
            bcnt  <= '0;
            blink <= 1'b1;
        end else begin
            state <= state_d;
            pre   <= pre_d;
            tick  <= tick_d;
            inc_r <= inc_d;
            bcnt  <= bcnt_d;
            blink <= blink_d;
        end
    end

    // Next-state, prescaler, blink and enable steering
    always_comb begin
        state_d     = state;
        pre_d       = '0;
        tick_d      = 1'b0;
        inc_d       = btn_inc && !btn_mode;
        bcnt_d      = '0;
        blink_d     = 1'b1;
        en_sec_ones = 1'b0;
        en_sec_tens = 1'b0;
        en_min_ones = 1'b0;
        en_min_tens = 1'b0;

        case (state)
            RUN:     if (btn_mode) state_d = SET_MIN;
            SET_MIN: if (btn_mode) state_d = SET_SEC;
            SET_SEC: if (btn_mode) state_d = RUN;
            default: state_d = RUN;
        endcase

        mode_chg = (state_d != state);
        in_set   = (state == SET_MIN) || (state == SET_SEC);

        // Prescaler runs only in a steady RUN; any mode change restarts it
        if ((state == RUN) && !mode_chg) begin
            pre_d = (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
        end
        tick_d = (state == RUN) && (pre == PRE_MAX) && (state_d == RUN);

        // Blink restarts visible on every set-mode entry
        if (in_set && !mode_chg) begin
            if (bcnt == BLINK_MAX) begin
                bcnt_d  = '0;
                blink_d = !blink;
            end else begin
                bcnt_d  = bcnt + BLINK_W'(1);
                blink_d = blink;
            end
        end

        case (state)
            RUN: begin
                en_sec_ones = tick;
                en_sec_tens = tc_sec_ones;
                en_min_ones = tc_sec_tens;
                en_min_tens = tc_min_ones;
            end
            SET_SEC: begin
                en_sec_ones = inc_r;
                en_sec_tens = tc_sec_ones;
            end
            SET_MIN: begin
                en_min_ones = inc_r;
                en_min_tens = tc_min_ones;
            end
            default: ;
        endcase
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with behavioural MM:SS digit counters.
module tb_clock_time_ctrl;

    logic clk = 1'b0;
    logic reset, btn_mode, btn_inc;
    logic tc_sec_ones, tc_sec_tens, tc_min_ones;
    logic en_sec_ones, en_sec_tens, en_min_ones, en_min_tens;
    logic [1:0] mode;
    logic tick, blink;

    logic [3:0] so, st, mo, mt;
    logic        load;
    logic [15:0] load_val;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clock_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .tc_sec_ones(tc_sec_ones), .tc_sec_tens(tc_sec_tens), .tc_min_ones(tc_min_ones),
        .en_sec_ones(en_sec_ones), .en_sec_tens(en_sec_tens),
        .en_min_ones(en_min_ones), .en_min_tens(en_min_tens),
        .mode(mode), .tick(tick), .blink(blink)
    );

    // Digit counters: tc = (Q == max) && en
    assign tc_sec_ones = (so == 4'd9) && en_sec_ones;
    assign tc_sec_tens = (st == 4'd5) && en_sec_tens;
    assign tc_min_ones = (mo == 4'd9) && en_min_ones;

    always @(posedge clk) begin
        if (load) begin
            {mt, mo, st, so} <= load_val;
        end else begin
            if (en_sec_ones) so <= (so == 4'd9) ? 4'd0 : so + 4'd1;
            if (en_sec_tens) st <= (st == 4'd5) ? 4'd0 : st + 4'd1;
            if (en_min_ones) mo <= (mo == 4'd9) ? 4'd0 : mo + 4'd1;
            if (en_min_tens) mt <= (mt == 4'd5) ? 4'd0 : mt + 4'd1;
        end
    end

    function automatic logic [15:0] now_time();
        return {mt, mo, st, so};
    endfunction

    function automatic logic [3:0] ens();
        return {en_min_tens, en_min_ones, en_sec_tens, en_sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks, mo_pulses, mo_at, errs;
        bit found;

        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        load = 1'b1; load_val = 16'h0000;
        step(); step();
        load = 1'b0;
        check("rst_mode",  32'(mode),  32'd0);
        check("rst_tick",  32'(tick),  32'd0);
        check("rst_blink", 32'(blink), 32'd1);
        check("rst_en",    32'(ens()), 32'd0);

        // 240 cycles of RUN: a tick every 4 cycles, minute carry on tick 60
        reset = 1'b0;
        ticks = 0; mo_pulses = 0; mo_at = 0; errs = 0;
        for (int i = 1; i <= 240; i++) begin
            step();
            if (tick !== ((i % 4) == 0)) errs++;
            if (tick) ticks++;
            if (en_min_ones) begin
                mo_pulses++;
                mo_at = ticks;
            end
        end
        check("run_tick_period", 32'(errs), 32'd0);
        check("run_tick_count", 32'(ticks), 32'd60);
        check("run_min_pulses", 32'(mo_pulses), 32'd1);
        check("run_min_at_tick", 32'(mo_at), 32'd60);
        step();
        check("run_time_0100", 32'(now_time()), 32'h0100);

        // Full hour rollover from 00:00
        load = 1'b1; load_val = 16'h0000;
        step();
        load = 1'b0;
        ticks = 0; found = 1'b0;
        for (int i = 0; i < 15000 && !found; i++) begin
            step();
            if (tick) begin
                ticks++;
                if (ticks == 3600) begin
                    found = 1'b1;
                    check("hour_all_en", 32'(ens()), 32'hF);
                    check("hour_pre_time", 32'(now_time()), 32'h5959);
                end
            end
        end
        check("hour_reached", 32'(found), 32'd1);
        step();
        check("hour_wrap_time", 32'(now_time()), 32'h0000);

        // From 12:34: enter SET_MIN and increment three times
        load = 1'b1; load_val = 16'h1234; btn_mode = 1'b1;
        step();
        load = 1'b0; btn_mode = 1'b0;
        check("setmin_mode", 32'(mode), 32'd1);
        errs = 0;
        for (int j = 0; j < 9; j++) begin
            check("setmin_blink", 32'(blink), 32'(((j / 3) % 2) == 0));
            if (tick || en_sec_ones || en_sec_tens) errs++;
            btn_inc = (j == 0 || j == 2 || j == 4);
            step();
        end
        btn_inc = 1'b0;
        check("setmin_no_tick_sec", 32'(errs), 32'd0);
        check("setmin_time", 32'(now_time()), 32'h1534);

        // 59:20 + 1 minute wraps to 00:20
        load = 1'b1; load_val = 16'h5920; btn_inc = 1'b1;
        step();
        load = 1'b0; btn_inc = 1'b0;
        check("min_wrap_en", 32'(ens()), 32'b1110 & 32'(ens()) | 32'b0010 & 32'(ens()));
        check("min_wrap_en_min_ones", 32'(en_min_ones), 32'd1);
        check("min_wrap_no_sec_en", 32'({en_sec_tens, en_sec_ones}), 32'd0);
        step();
        check("min_wrap_time", 32'(now_time()), 32'h0020);

        // SET_SEC: 45 increments from :20 wrap to :05 without minute carry
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        check("setsec_mode", 32'(mode), 32'd2);
        errs = 0;
        for (int j = 0; j < 90; j++) begin
            if (en_min_ones || en_min_tens || tick) errs++;
            btn_inc = ((j % 2) == 0);
            step();
        end
        btn_inc = 1'b0;
        step();
        if (en_min_ones || en_min_tens) errs++;
        check("setsec_no_min_carry", 32'(errs), 32'd0);
        check("setsec_time", 32'(now_time()), 32'h0005);

        // Back round to SET_MIN, then simultaneous mode+inc
        btn_mode = 1'b1;
        step();
        check("cycle_run", 32'(mode), 32'd0);
        step();
        btn_mode = 1'b0;
        check("cycle_setmin", 32'(mode), 32'd1);
        btn_mode = 1'b1; btn_inc = 1'b1;
        step();
        btn_mode = 1'b0; btn_inc = 1'b0;
        check("both_mode", 32'(mode), 32'd2);
        check("both_no_en", 32'(ens()), 32'd0);
        step();
        check("both_no_en_late", 32'(ens()), 32'd0);
        check("both_time", 32'(now_time()), 32'h0005);

        // Reset in SET_SEC during the blanked phase
        step(); step();
        check("pre_rst_blink", 32'(blink), 32'd0);
        reset = 1'b1;
        step();
        check("mid_rst_mode",  32'(mode),  32'd0);
        check("mid_rst_blink", 32'(blink), 32'd1);
        check("mid_rst_tick",  32'(tick),  32'd0);
        reset = 1'b0;
        errs = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (tick) errs++;
        end
        check("post_rst_no_early_tick", 32'(errs), 32'd0);
        step();
        check("post_rst_first_tick", 32'(tick), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
